// File: rtl/mipi_csi_lite_rx.sv
// Lightweight 4-lane camera packet receiver.
// Hunts for a zero leader plus C-F-C sync and decodes frame-start, line-start and pixel-data
// packets. Pixel packets are reassembled into 16-bit pixels with a line-buffer write address.
// Optional: define MIPI_DEBUG_STATE_EN to export the one-hot FSM state on db_state.
module mipi_csi_lite_rx #(
  parameter int unsigned LINE_PIXELS    = 960,
  parameter int unsigned ADDR_W         = 10,
  parameter int unsigned LEADER_NIBBLES = 8,
  parameter int unsigned HEAD_NIBBLES   = 4
) (
  input  logic              CAM_CLK,
  input  logic              RESET,
  input  logic [3:0]        CAM_DATA_i,
  output logic              VSYNC,
  output logic              HSYNC,
  output logic              LINE_END,
  output logic              PCLK,
  output logic [15:0]       DATA_OUT,
  output logic [ADDR_W-1:0] ADDRA
`ifdef MIPI_DEBUG_STATE_EN
  ,
  output logic [5:0]        db_state
`endif
);

  // Zero-run counter must reach LEADER_NIBBLES+1 (leader plus the sync's leading zero).
  localparam int unsigned ZrunW = $clog2(LEADER_NIBBLES + 2);
  // One counter serves the type, header and pixel nibble phases.
  localparam int unsigned CntW  = (HEAD_NIBBLES > 4) ? $clog2(HEAD_NIBBLES) : 2;

  localparam logic [ZrunW-1:0]  ZrunMin  = ZrunW'(LEADER_NIBBLES + 1);
  localparam logic [CntW-1:0]   HeadLast = CntW'(HEAD_NIBBLES - 1);
  localparam logic [CntW-1:0]   NibLast  = CntW'(3);
  localparam logic [ADDR_W-1:0] PixLast  = ADDR_W'(LINE_PIXELS - 1);

  // One-hot encoding doubles as the debug state view.
  typedef enum logic [5:0] {
    StHunt   = 6'b000001,
    StSyncF  = 6'b000010,
    StSyncC2 = 6'b000100,
    StType   = 6'b001000,
    StHead   = 6'b010000,
    StData   = 6'b100000
  } state_e;

  state_e             state_q, state_d;
  logic [ZrunW-1:0]   zrun_q, zrun_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [11:0]        shift_q, shift_d;
  logic [ADDR_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic               vsync_q, vsync_d;
  logic               hsync_q, hsync_d;
  logic               pclk_q, pclk_d;
  logic               line_end_q, line_end_d;
  logic [15:0]        data_q, data_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;

  logic               nib_zero;
  logic [ZrunW-1:0]   zrun_restart;
  logic [15:0]        word_full;

  assign nib_zero     = (CAM_DATA_i == 4'h0);
  // On any return to HUNT the current nibble may already start a new leader.
  assign zrun_restart = {{(ZrunW-1){1'b0}}, nib_zero};
  assign word_full    = {shift_q, CAM_DATA_i};

  // Next-state and registered-output decode.
  always_comb begin
    state_d    = state_q;
    zrun_d     = zrun_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    pix_cnt_d  = pix_cnt_q;
    vsync_d    = 1'b0;
    hsync_d    = 1'b0;
    pclk_d     = 1'b0;
    line_end_d = 1'b0;
    data_d     = data_q;
    addr_d     = addr_q;

    unique case (state_q)
      StHunt: begin
        if (nib_zero) begin
          if (zrun_q != '1) zrun_d = zrun_q + 1'b1;
        end else begin
          zrun_d = '0;
          if (CAM_DATA_i == 4'hC && zrun_q >= ZrunMin) state_d = StSyncF;
        end
      end
      StSyncF: begin
        if (CAM_DATA_i == 4'hF) begin
          state_d = StSyncC2;
        end else begin
          state_d = StHunt;
          zrun_d  = zrun_restart;
        end
      end
      StSyncC2: begin
        if (CAM_DATA_i == 4'hC) begin
          state_d = StType;
          cnt_d   = '0;
        end else begin
          state_d = StHunt;
          zrun_d  = zrun_restart;
        end
      end
      StType: begin
        shift_d = word_full[11:0];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == NibLast) begin
          state_d = StHunt;
          zrun_d  = zrun_restart;
          if (word_full == 16'h0000) begin
            vsync_d = 1'b1;
          end else if (word_full == 16'hC000) begin
            hsync_d = 1'b1;
          end else if (word_full == 16'hCCC0) begin
            state_d = StHead;
            cnt_d   = '0;
          end
        end
      end
      StHead: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == HeadLast) begin
          state_d   = StData;
          cnt_d     = '0;
          pix_cnt_d = '0;
        end
      end
      StData: begin
        // Zero runs here are pixel data; resync only after the line completes.
        shift_d = word_full[11:0];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == NibLast) begin
          cnt_d  = '0;
          pclk_d = 1'b1;
          data_d = word_full;
          addr_d = pix_cnt_q;
          if (pix_cnt_q == PixLast) begin
            line_end_d = 1'b1;
            pix_cnt_d  = '0;
            state_d    = StHunt;
            zrun_d     = zrun_restart;
          end else begin
            pix_cnt_d = pix_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = StHunt;
        zrun_d  = '0;
      end
    endcase
  end

  // State and output registers; reset aborts any packet in flight.
  always_ff @(posedge CAM_CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= StHunt;
      zrun_q     <= '0;
      cnt_q      <= '0;
      shift_q    <= '0;
      pix_cnt_q  <= '0;
      vsync_q    <= 1'b0;
      hsync_q    <= 1'b0;
      pclk_q     <= 1'b0;
      line_end_q <= 1'b0;
      data_q     <= '0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      zrun_q     <= zrun_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      pix_cnt_q  <= pix_cnt_d;
      vsync_q    <= vsync_d;
      hsync_q    <= hsync_d;
      pclk_q     <= pclk_d;
      line_end_q <= line_end_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
    end
  end

  assign VSYNC    = vsync_q;
  assign HSYNC    = hsync_q;
  assign PCLK     = pclk_q;
  assign LINE_END = line_end_q;
  assign DATA_OUT = data_q;
  assign ADDRA    = addr_q;

`ifdef MIPI_DEBUG_STATE_EN
  assign db_state = state_q;
`endif

endmodule

// File: tb/tb_mipi_csi_lite_rx.sv
// Self-checking bench for mipi_csi_lite_rx: packets are composed as nibble streams and the
// expected strobes are attached to the nibble that completes each packet or pixel.
module tb_mipi_csi_lite_rx;

  localparam int unsigned LinePix = 960;
  localparam int unsigned AddrW   = 10;

  logic             cam_clk = 1'b0;
  logic             rst_n   = 1'b0;
  logic [3:0]       cam_data = 4'h0;
  logic             vsync, hsync, line_end, pclk;
  logic [15:0]      data_out;
  logic [AddrW-1:0] addra;
`ifdef MIPI_DEBUG_STATE_EN
  logic [5:0]       db_state;
`endif

  mipi_csi_lite_rx #(
    .LINE_PIXELS   (LinePix),
    .ADDR_W        (AddrW),
    .LEADER_NIBBLES(8),
    .HEAD_NIBBLES  (4)
  ) dut (
    .CAM_CLK   (cam_clk),
    .RESET     (rst_n),
    .CAM_DATA_i(cam_data),
    .VSYNC     (vsync),
    .HSYNC     (hsync),
    .LINE_END  (line_end),
    .PCLK      (pclk),
    .DATA_OUT  (data_out),
    .ADDRA     (addra)
`ifdef MIPI_DEBUG_STATE_EN
    ,
    .db_state  (db_state)
`endif
  );

  always #5 cam_clk = ~cam_clk;

  typedef struct packed {
    logic [3:0]       nib;
    logic             vs;
    logic             hs;
    logic             pc;
    logic             le;
    logic [15:0]      d;
    logic [AddrW-1:0] a;
  } step_t;

  step_t            stq[$];
  logic [15:0]      hold_d;
  logic [AddrW-1:0] hold_a;
  int               n_pass = 0;
  int               n_total = 0;
  int               vs_seen, hs_seen, pc_seen, le_seen;

  task automatic push(input logic [3:0] nib, input logic vs, input logic hs, input logic pc,
                      input logic le);
    step_t s;
    s.nib = nib; s.vs = vs; s.hs = hs; s.pc = pc; s.le = le;
    s.d = hold_d; s.a = hold_a;
    stq.push_back(s);
  endtask

  task automatic push_filler(input int n);
    for (int i = 0; i < n; i++) push(4'($urandom_range(1, 15)), 0, 0, 0, 0);
  endtask

  task automatic push_leader(input int zeros);
    for (int i = 0; i < zeros; i++) push(4'h0, 0, 0, 0, 0);
    push(4'hC, 0, 0, 0, 0);
    push(4'hF, 0, 0, 0, 0);
    push(4'hC, 0, 0, 0, 0);
  endtask

  task automatic push_frame_start(input int zeros);
    push_leader(zeros);
    for (int i = 0; i < 3; i++) push(4'h0, 0, 0, 0, 0);
    push(4'h0, 1, 0, 0, 0);
  endtask

  task automatic push_line_start(input int zeros);
    push_leader(zeros);
    push(4'hC, 0, 0, 0, 0);
    push(4'h0, 0, 0, 0, 0);
    push(4'h0, 0, 0, 0, 0);
    push(4'h0, 0, 1, 0, 0);
  endtask

  task automatic push_unknown(input int zeros, input logic [15:0] code);
    push_leader(zeros);
    push(code[15:12], 0, 0, 0, 0);
    push(code[11:8], 0, 0, 0, 0);
    push(code[7:4], 0, 0, 0, 0);
    push(code[3:0], 0, 0, 0, 0);
  endtask

  task automatic push_data_header(input int zeros);
    push_leader(zeros);
    push(4'hC, 0, 0, 0, 0);
    push(4'hC, 0, 0, 0, 0);
    push(4'hC, 0, 0, 0, 0);
    push(4'h0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) push(4'($urandom_range(0, 15)), 0, 0, 0, 0);
  endtask

  task automatic push_pixel(input logic [15:0] val, input int idx);
    logic [AddrW-1:0] a;
    a = AddrW'(idx);
    push(val[15:12], 0, 0, 0, 0);
    push(val[11:8], 0, 0, 0, 0);
    push(val[7:4], 0, 0, 0, 0);
    hold_d = val;
    hold_a = a;
    push(val[3:0], 0, 0, 1, (idx == int'(LinePix) - 1));
  endtask

  task automatic push_random_line(input int zeros);
    push_data_header(zeros);
    for (int p = 0; p < int'(LinePix); p++) push_pixel(16'($urandom), p);
  endtask

  task automatic clear_seen();
    vs_seen = 0; hs_seen = 0; pc_seen = 0; le_seen = 0;
  endtask

  // Drive the queued nibbles, one per clock, comparing every cycle's outputs.
  task automatic run_stream(input string name);
    step_t s;
    int    cyc;
    cyc = 0;
    while (stq.size() > 0) begin
      s = stq.pop_front();
      cam_data = s.nib;
      @(posedge cam_clk);
      #1;
      n_total++;
      if ({vsync, hsync, pclk, line_end, data_out, addra} !==
          {s.vs, s.hs, s.pc, s.le, s.d, s.a}) begin
        $display("FAIL %s cycle %0d: got vs=%b hs=%b pclk=%b le=%b data=%h addr=%0d, expected vs=%b hs=%b pclk=%b le=%b data=%h addr=%0d",
                 name, cyc, vsync, hsync, pclk, line_end, data_out, addra,
                 s.vs, s.hs, s.pc, s.le, s.d, s.a);
      end else begin
        n_pass++;
      end
      vs_seen += int'(vsync);
      hs_seen += int'(hsync);
      pc_seen += int'(pclk);
      le_seen += int'(line_end);
      cyc++;
    end
  endtask

  task automatic check_counts(input string name, input int vs, input int hs, input int pc,
                              input int le);
    n_total++;
    if (vs_seen !== vs || hs_seen !== hs || pc_seen !== pc || le_seen !== le) begin
      $display("FAIL %s pulse counts: got vs=%0d hs=%0d pclk=%0d le=%0d, expected vs=%0d hs=%0d pclk=%0d le=%0d",
               name, vs_seen, hs_seen, pc_seen, le_seen, vs, hs, pc, le);
    end else begin
      n_pass++;
    end
  endtask

  task automatic check_idle_zero(input string name);
    n_total++;
    if ({vsync, hsync, pclk, line_end, data_out, addra} !== '0) begin
      $display("FAIL %s: got vs=%b hs=%b pclk=%b le=%b data=%h addr=%0d, expected all zero",
               name, vsync, hsync, pclk, line_end, data_out, addra);
    end else begin
      n_pass++;
    end
`ifdef MIPI_DEBUG_STATE_EN
    n_total++;
    if (db_state !== 6'b000001) begin
      $display("FAIL %s db_state: got %b, expected 000001", name, db_state);
    end else begin
      n_pass++;
    end
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cam_data = 4'($urandom_range(0, 15));
    repeat (3) @(posedge cam_clk);
    #1;
    check_idle_zero("reset");
    rst_n = 1'b1;
    hold_d = '0;
    hold_a = '0;
  endtask

  task automatic test_frame_start();
    clear_seen();
    push(4'h3, 0, 0, 0, 0);
    push_frame_start(9);
    run_stream("frame_start");
    check_counts("frame_start", 1, 0, 0, 0);
  endtask

  task automatic test_line_start();
    clear_seen();
    push_filler(2);
    push_line_start(9);
    run_stream("line_start");
    check_counts("line_start", 0, 1, 0, 0);
  endtask

  task automatic test_line_ramp();
    logic [15:0] v;
    clear_seen();
    push_leader(9);
    push(4'hC, 0, 0, 0, 0);
    push(4'hC, 0, 0, 0, 0);
    push(4'hC, 0, 0, 0, 0);
    push(4'h0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) push(4'hF, 0, 0, 0, 0);
    // Pixel p is built from nibbles (4p .. 4p+3) mod 16.
    for (int p = 0; p < int'(LinePix); p++) begin
      v = {4'((4 * p) % 16), 4'((4 * p + 1) % 16), 4'((4 * p + 2) % 16), 4'((4 * p + 3) % 16)};
      push_pixel(v, p);
    end
    run_stream("line_ramp");
    check_counts("line_ramp", 0, 0, int'(LinePix), 1);
    n_total++;
    if (data_out !== 16'hCDEF || addra !== AddrW'(LinePix - 1)) begin
      $display("FAIL line_ramp last pixel: got data=%h addr=%0d, expected data=cdef addr=%0d",
               data_out, addra, LinePix - 1);
    end else begin
      n_pass++;
    end
  endtask

  task automatic test_filler_badsync();
    clear_seen();
    for (int i = 0; i < 6; i++) push(4'h5, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) push(4'h0, 0, 0, 0, 0);
    push(4'hC, 0, 0, 0, 0);
    push(4'hE, 0, 0, 0, 0);
    push_filler(3);
    for (int i = 0; i < 10; i++) push(4'h0, 0, 0, 0, 0);
    push(4'hC, 0, 0, 0, 0);
    push(4'hF, 0, 0, 0, 0);
    push(4'hE, 0, 0, 0, 0);
    push_filler(2);
    // One zero short of a valid leader: a would-be frame start is ignored.
    for (int i = 0; i < 8; i++) push(4'h0, 0, 0, 0, 0);
    push(4'hC, 0, 0, 0, 0);
    push(4'hF, 0, 0, 0, 0);
    push(4'hC, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) push(4'h0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) push(4'h5, 0, 0, 0, 0);
    push_line_start(9);
    run_stream("filler_badsync");
    check_counts("filler_badsync", 0, 1, 0, 0);
  endtask

  task automatic test_unknown_type();
    logic [15:0] code;
    clear_seen();
    push_unknown(9, 16'h1234);
    push_filler(2);
    for (int k = 0; k < 3; k++) begin
      do code = 16'($urandom); while (code == 16'h0000 || code == 16'hC000 || code == 16'hCCC0);
      push_unknown(9 + k, code);
      push_filler(1);
    end
    run_stream("unknown_type");
    check_counts("unknown_type", 0, 0, 0, 0);
    clear_seen();
    push_frame_start(9);
    run_stream("after_unknown");
    check_counts("after_unknown", 1, 0, 0, 0);
  endtask

  task automatic test_reset_mid_line();
    logic [15:0] v;
    clear_seen();
    push_filler(2);
    push_data_header(10);
    for (int p = 0; p < 100; p++) push_pixel(16'($urandom), p);
    v = 16'($urandom);
    push(v[15:12], 0, 0, 0, 0);
    push(v[11:8], 0, 0, 0, 0);
    run_stream("pre_reset_line");
    check_counts("pre_reset_line", 0, 0, 100, 0);
    rst_n = 1'b0;
    #2;
    check_idle_zero("reset_mid_line");
    repeat (2) @(posedge cam_clk);
    #1;
    rst_n = 1'b1;
    hold_d = '0;
    hold_a = '0;
    clear_seen();
    // Remainder of the aborted line must not produce pixels.
    for (int i = 0; i < 200; i++) push(4'((i + 3) % 16), 0, 0, 0, 0);
    run_stream("post_reset_garbage");
    check_counts("post_reset_garbage", 0, 0, 0, 0);
    clear_seen();
    push_filler(1);
    push_random_line(9);
    run_stream("post_reset_line");
    check_counts("post_reset_line", 0, 0, int'(LinePix), 1);
  endtask

  task automatic test_random_mix();
    logic [15:0] code;
    int          kind, evs, ehs, epc, ele;
    clear_seen();
    evs = 0; ehs = 0; epc = 0; ele = 0;
    for (int k = 0; k < 24; k++) begin
      push_filler($urandom_range(0, 5));
      kind = (k == 6 || k == 17) ? 5 : $urandom_range(0, 4);
      case (kind)
        0: begin push_frame_start($urandom_range(9, 13)); evs++; end
        1: begin push_line_start($urandom_range(9, 13)); ehs++; end
        2: push_filler($urandom_range(1, 8));
        3: begin
          for (int i = 0; i < 9; i++) push(4'h0, 0, 0, 0, 0);
          push(4'hC, 0, 0, 0, 0);
          push(4'($urandom_range(1, 14)), 0, 0, 0, 0);
        end
        4: begin
          do code = 16'($urandom); while (code == 16'h0000 || code == 16'hC000 ||
                                          code == 16'hCCC0);
          push_unknown($urandom_range(9, 12), code);
        end
        default: begin
          push_random_line($urandom_range(9, 12));
          epc += int'(LinePix);
          ele++;
        end
      endcase
    end
    push_filler(2);
    run_stream("random_mix");
    check_counts("random_mix", evs, ehs, epc, ele);
  endtask

  initial begin
    hold_d = '0;
    hold_a = '0;
    test_reset();
    test_frame_start();
    test_line_start();
    test_line_ramp();
    test_filler_badsync();
    test_unknown_type();
    test_reset_mid_line();
    test_random_mix();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
